// File: rtl/uart_csr_fifo.sv
// uart_csr_fifo: APB slave register file for the UART with TX/RX FIFOs,
// byte-strobe merging, PSLVERR responses, sticky W1C interrupts and an IRQ.
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   psel_i/penable_i/pwrite_i/paddr_i  APB control and byte address
//   pwdata_i/pstrb_i                   APB write data and byte-lane strobes
//   prdata_o/pready_o/pslverr_o        APB response (valid in access phase)
//   tx_valid_o/tx_data_o/tx_ready_i    TX FIFO head towards the UART TX engine
//   rx_valid_i/rx_data_i               received character pulse from UART RX
//   parity_error_i                     parity flag qualified by rx_valid_i
//   data_bit_num_o .. parity_type_o    CFG register fields
//   irq_o                              registered interrupt request
module uart_csr_fifo #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned TX_DEPTH = 16,
  parameter int unsigned RX_DEPTH = 16,
  parameter int unsigned ADDR_W   = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic [31:0]       pwdata_i,
  input  logic [3:0]        pstrb_i,
  output logic [31:0]       prdata_o,
  output logic              pready_o,
  output logic              pslverr_o,
  output logic              tx_valid_o,
  output logic [DATA_W-1:0] tx_data_o,
  input  logic              tx_ready_i,
  input  logic              rx_valid_i,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              parity_error_i,
  output logic [1:0]        data_bit_num_o,
  output logic              stop_bit_num_o,
  output logic              parity_en_o,
  output logic              parity_type_o,
  output logic              irq_o
);

  localparam int unsigned TX_PW = $clog2(TX_DEPTH);
  localparam int unsigned TX_CW = TX_PW + 1;
  localparam int unsigned RX_PW = $clog2(RX_DEPTH);
  localparam int unsigned RX_CW = RX_PW + 1;
  localparam int unsigned INT_W = 5;
  localparam int unsigned CFG_W = 5;

  localparam logic [ADDR_W-1:0] A_TX_DATA = ADDR_W'(32'h00);
  localparam logic [ADDR_W-1:0] A_RX_DATA = ADDR_W'(32'h04);
  localparam logic [ADDR_W-1:0] A_CFG     = ADDR_W'(32'h08);
  localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(32'h0C);
  localparam logic [ADDR_W-1:0] A_STT     = ADDR_W'(32'h10);
  localparam logic [ADDR_W-1:0] A_INT_EN  = ADDR_W'(32'h14);
  localparam logic [ADDR_W-1:0] A_INT_STT = ADDR_W'(32'h18);

  // Register state
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic             tx_en_q, tx_en_d;
  logic             rx_en_q, rx_en_d;
  logic [INT_W-1:0] int_en_q, int_en_d;
  logic [INT_W-1:0] int_stt_q, int_stt_d;
  logic             irq_q, irq_d;

  // FIFO state
  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [TX_PW-1:0]  tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [TX_CW-1:0]  tx_cnt_q, tx_cnt_d;
  logic [RX_PW-1:0]  rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [RX_CW-1:0]  rx_cnt_q, rx_cnt_d;

  // Decode / event signals
  logic        access;
  logic        tx_empty, tx_full, rx_empty, rx_full;
  logic        tx_push, tx_pop, tx_ovf, tx_flush;
  logic        rx_in, rx_push, rx_pop, rx_ovr, rx_par, rx_flush;
  logic        cfg_we, ctrl_we, int_en_we, w1c_we;
  logic [31:0] stt_word;
  logic [INT_W-1:0] int_set;
  logic        unused_bits;

  assign access   = psel_i & penable_i;
  assign pready_o = 1'b1;

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == TX_CW'(TX_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == RX_CW'(RX_DEPTH));

  assign tx_valid_o = tx_en_q & ~tx_empty;
  assign tx_data_o  = tx_empty ? '0 : tx_mem[tx_rd_q];
  assign tx_pop     = tx_valid_o & tx_ready_i;

  assign rx_in   = rx_valid_i & rx_en_q;
  assign rx_push = rx_in & ~rx_full;
  assign rx_par  = rx_in & parity_error_i;
  // A flushed overrun is discarded silently
  assign rx_ovr  = rx_in & rx_full & ~rx_flush;

  assign tx_flush = ctrl_we & pwdata_i[2];
  assign rx_flush = ctrl_we & pwdata_i[3];

  assign stt_word = {8'h00, 8'(rx_cnt_q), 8'(tx_cnt_q),
                     4'h0, rx_full, rx_empty, tx_full, tx_empty};

  assign unused_bits = ^{pwdata_i[31:DATA_W], pstrb_i[3:1]};

  // APB decode: read mux, error response and per-register write enables
  always_comb begin
    prdata_o  = '0;
    pslverr_o = 1'b0;
    tx_push   = 1'b0;
    tx_ovf    = 1'b0;
    rx_pop    = 1'b0;
    cfg_we    = 1'b0;
    ctrl_we   = 1'b0;
    int_en_we = 1'b0;
    w1c_we    = 1'b0;
    if (access) begin
      case (paddr_i)
        A_TX_DATA: begin
          if (!pwrite_i) begin
            pslverr_o = 1'b1;
          end else if (pstrb_i[0]) begin
            // Fullness is judged before any same-cycle pop
            if (tx_full) begin
              pslverr_o = 1'b1;
              tx_ovf    = 1'b1;
            end else begin
              tx_push = 1'b1;
            end
          end
        end
        A_RX_DATA: begin
          if (pwrite_i || rx_empty) begin
            pslverr_o = 1'b1;
          end else begin
            prdata_o = 32'(rx_mem[rx_rd_q]);
            rx_pop   = 1'b1;
          end
        end
        A_CFG: begin
          if (pwrite_i) cfg_we = pstrb_i[0];
          else          prdata_o = 32'(cfg_q);
        end
        A_CTRL: begin
          if (pwrite_i) ctrl_we = pstrb_i[0];
          else          prdata_o = 32'({rx_en_q, tx_en_q});
        end
        A_STT: begin
          if (pwrite_i) pslverr_o = 1'b1;
          else          prdata_o  = stt_word;
        end
        A_INT_EN: begin
          if (pwrite_i) int_en_we = pstrb_i[0];
          else          prdata_o  = 32'(int_en_q);
        end
        A_INT_STT: begin
          if (pwrite_i) w1c_we   = pstrb_i[0];
          else          prdata_o = 32'(int_stt_q);
        end
        default: pslverr_o = 1'b1;
      endcase
    end
  end

  // Control/status register next state; hardware set beats W1C
  always_comb begin
    cfg_d    = cfg_we    ? pwdata_i[CFG_W-1:0] : cfg_q;
    int_en_d = int_en_we ? pwdata_i[INT_W-1:0] : int_en_q;
    tx_en_d  = ctrl_we   ? pwdata_i[0] : tx_en_q;
    rx_en_d  = ctrl_we   ? pwdata_i[1] : rx_en_q;
    int_set  = {tx_ovf, rx_par, rx_ovr, ~rx_empty, tx_empty};
    int_stt_d = (int_stt_q & ~(w1c_we ? pwdata_i[INT_W-1:0] : '0)) | int_set;
    irq_d    = |(int_stt_q & int_en_q);
  end

  // TX FIFO pointers and occupancy; flush wins over push/pop
  always_comb begin
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    tx_cnt_d = tx_cnt_q;
    if (tx_flush) begin
      tx_wr_d  = '0;
      tx_rd_d  = '0;
      tx_cnt_d = '0;
    end else begin
      if (tx_push) tx_wr_d = tx_wr_q + TX_PW'(1);
      if (tx_pop)  tx_rd_d = tx_rd_q + TX_PW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt_d = tx_cnt_q + TX_CW'(1);
        2'b01:   tx_cnt_d = tx_cnt_q - TX_CW'(1);
        default: tx_cnt_d = tx_cnt_q;
      endcase
    end
  end

  // RX FIFO pointers and occupancy; flush wins over push/pop
  always_comb begin
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    rx_cnt_d = rx_cnt_q;
    if (rx_flush) begin
      rx_wr_d  = '0;
      rx_rd_d  = '0;
      rx_cnt_d = '0;
    end else begin
      if (rx_push) rx_wr_d = rx_wr_q + RX_PW'(1);
      if (rx_pop)  rx_rd_d = rx_rd_q + RX_PW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt_d = rx_cnt_q + RX_CW'(1);
        2'b01:   rx_cnt_d = rx_cnt_q - RX_CW'(1);
        default: rx_cnt_d = rx_cnt_q;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_q     <= '0;
      tx_en_q   <= 1'b0;
      rx_en_q   <= 1'b0;
      int_en_q  <= '0;
      int_stt_q <= '0;
      irq_q     <= 1'b0;
      tx_wr_q   <= '0;
      tx_rd_q   <= '0;
      tx_cnt_q  <= '0;
      rx_wr_q   <= '0;
      rx_rd_q   <= '0;
      rx_cnt_q  <= '0;
    end else begin
      cfg_q     <= cfg_d;
      tx_en_q   <= tx_en_d;
      rx_en_q   <= rx_en_d;
      int_en_q  <= int_en_d;
      int_stt_q <= int_stt_d;
      irq_q     <= irq_d;
      tx_wr_q   <= tx_wr_d;
      tx_rd_q   <= tx_rd_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_wr_q   <= rx_wr_d;
      rx_rd_q   <= rx_rd_d;
      rx_cnt_q  <= rx_cnt_d;
    end
  end

  // FIFO storage needs no reset: occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (tx_push && !tx_flush) tx_mem[tx_wr_q] <= pwdata_i[DATA_W-1:0];
    if (rx_push && !rx_flush) rx_mem[rx_wr_q] <= rx_data_i;
  end

  assign data_bit_num_o = cfg_q[1:0];
  assign stop_bit_num_o = cfg_q[2];
  assign parity_en_o    = cfg_q[3];
  assign parity_type_o  = cfg_q[4];
  assign irq_o          = irq_q;

endmodule

// File: tb/tb_uart_csr_fifo.sv
// tb_uart_csr_fifo: self-checking bench for uart_csr_fifo. Register table,
// directed FIFO/interrupt sequences, then random traffic against a queue model.
module tb_uart_csr_fifo;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        psel_i, penable_i, pwrite_i;
  logic [11:0] paddr_i;
  logic [31:0] pwdata_i;
  logic [3:0]  pstrb_i;
  logic [31:0] prdata_o;
  logic        pready_o, pslverr_o;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready_i;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        parity_error_i;
  logic [1:0]  data_bit_num_o;
  logic        stop_bit_num_o, parity_en_o, parity_type_o, irq_o;

  uart_csr_fifo dut (
    .clk(clk), .reset_n(reset_n),
    .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i),
    .paddr_i(paddr_i), .pwdata_i(pwdata_i), .pstrb_i(pstrb_i),
    .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
    .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .parity_error_i(parity_error_i),
    .data_bit_num_o(data_bit_num_o), .stop_bit_num_o(stop_bit_num_o),
    .parity_en_o(parity_en_o), .parity_type_o(parity_type_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // One APB transfer; called at posedge+1, returns at posedge+1
  task automatic apb(input bit wr, input logic [11:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd, output logic err);
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr;
    paddr_i = a; pwdata_i = d; pstrb_i = s;
    @(posedge clk); #1;
    penable_i = 1'b1;
    #2;
    rd  = prdata_o;
    err = pslverr_o;
    @(posedge clk); #1;
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0; pstrb_i = 4'h0;
  endtask

  task automatic rx_pulse(input logic [7:0] d, input logic par);
    rx_valid_i = 1'b1; rx_data_i = d; parity_error_i = par;
    @(posedge clk); #1;
    rx_valid_i = 1'b0; parity_error_i = 1'b0;
  endtask

  // Register access table
  typedef struct {
    string       name;
    bit          wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;
  vec_t vt[$];

  function automatic void add(input string n, input bit w, input logic [11:0] a,
                              input logic [31:0] d, input logic [3:0] s,
                              input logic [31:0] e, input bit ee);
    vt.push_back('{n, w, a, d, s, e, ee});
  endfunction

  // Reference model: FIFOs as queues, interrupts as sticky bits sampled per edge
  logic [7:0] m_txq[$];
  logic [7:0] m_rxq[$];
  logic [4:0] m_stt, m_en;
  bit         m_irq, m_txen, m_rxen;

  function automatic void m_tick(input logic [4:0] ev, input logic [4:0] w1c);
    logic [4:0] lvl;
    lvl = 5'h00;
    lvl[0] = (m_txq.size() == 0);
    lvl[1] = (m_rxq.size() != 0);
    m_irq = |(m_stt & m_en);
    m_stt = (m_stt & ~w1c) | ev | lvl;
  endfunction

  function automatic logic [31:0] m_stt_word();
    logic [31:0] w;
    w = 32'h0;
    w[0] = (m_txq.size() == 0);
    w[1] = (m_txq.size() == 16);
    w[2] = (m_rxq.size() == 0);
    w[3] = (m_rxq.size() == 16);
    w[15:8]  = 8'(m_txq.size());
    w[23:16] = 8'(m_rxq.size());
    return w;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] rd;
  logic        er;
  logic [7:0]  b;
  logic [31:0] d;
  logic [4:0]  ev;
  bit          full, par, expv;
  int          op;

  initial begin
    reset_n = 1'b0;
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    paddr_i = '0; pwdata_i = '0; pstrb_i = '0;
    tx_ready_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = '0; parity_error_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    chk("rst_tx_valid", 32'(tx_valid_o), 32'h0);
    chk("rst_tx_data", 32'(tx_data_o), 32'h0);
    chk("rst_irq", 32'(irq_o), 32'h0);
    chk("rst_prdata", prdata_o, 32'h0);
    chk("rst_pslverr", 32'(pslverr_o), 32'h0);
    chk("rst_pready", 32'(pready_o), 32'h1);
    chk("rst_cfg", 32'({parity_type_o, parity_en_o, stop_bit_num_o, data_bit_num_o}), 32'h0);

    // Register map table
    add("stt_reset",    0, 12'h010, 32'h0,        4'h0, 32'h5,  0);
    add("misaligned",   0, 12'h002, 32'h0,        4'h0, 32'h0,  1);
    add("unmapped_w",   1, 12'h01C, 32'h1,        4'hF, 32'h0,  1);
    add("unmapped_r",   0, 12'h100, 32'h0,        4'h0, 32'h0,  1);
    add("txdata_rd",    0, 12'h000, 32'h0,        4'h0, 32'h0,  1);
    add("rxdata_wr",    1, 12'h004, 32'h0,        4'hF, 32'h0,  1);
    add("stt_wr",       1, 12'h010, 32'h0,        4'hF, 32'h0,  1);
    add("rx_empty_rd",  0, 12'h004, 32'h0,        4'h0, 32'h0,  1);
    add("cfg_wr_lane1", 1, 12'h008, 32'hFFFFFFFF, 4'h2, 32'h0,  0);
    add("cfg_rd0",      0, 12'h008, 32'h0,        4'h0, 32'h0,  0);
    add("cfg_wr_lane0", 1, 12'h008, 32'h1D,       4'h1, 32'h0,  0);
    add("cfg_rd1",      0, 12'h008, 32'h0,        4'h0, 32'h1D, 0);
    add("inten_wr",     1, 12'h014, 32'hFFFFFFFF, 4'hF, 32'h0,  0);
    add("inten_rd",     0, 12'h014, 32'h0,        4'h0, 32'h1F, 0);
    add("inten_nostrb", 1, 12'h014, 32'h0,        4'h0, 32'h0,  0);
    add("inten_rd2",    0, 12'h014, 32'h0,        4'h0, 32'h1F, 0);
    add("inten_clr",    1, 12'h014, 32'h0,        4'hF, 32'h0,  0);
    add("inten_rd3",    0, 12'h014, 32'h0,        4'h0, 32'h0,  0);
    add("ctrl_wr",      1, 12'h00C, 32'h0F,       4'h1, 32'h0,  0);
    add("ctrl_rd",      0, 12'h00C, 32'h0,        4'h0, 32'h3,  0);
    add("ctrl_clr",     1, 12'h00C, 32'h0,        4'h1, 32'h0,  0);
    add("ctrl_rd2",     0, 12'h00C, 32'h0,        4'h0, 32'h0,  0);
    add("misaligned2",  0, 12'h00E, 32'h0,        4'h0, 32'h0,  1);
    foreach (vt[i]) begin
      apb(vt[i].wr, vt[i].addr, vt[i].data, vt[i].strb, rd, er);
      chk({vt[i].name, "_err"}, 32'(er), 32'(vt[i].exp_err));
      if (!vt[i].wr) chk({vt[i].name, "_rd"}, rd, vt[i].exp_rd);
    end
    chk("cfg_bits", 32'(data_bit_num_o), 32'h1);
    chk("cfg_stop", 32'(stop_bit_num_o), 32'h1);
    chk("cfg_pen", 32'(parity_en_o), 32'h1);
    chk("cfg_ptype", 32'(parity_type_o), 32'h1);

    // TX fill to full, then overflow
    apb(1, 12'h00C, 32'h1, 4'h1, rd, er);
    for (int i = 0; i < 16; i++) begin
      apb(1, 12'h000, 32'h41 + 32'(i), 4'h1, rd, er);
      chk("tx_fill_err", 32'(er), 32'h0);
    end
    apb(0, 12'h010, 32'h0, 4'h0, rd, er);
    chk("tx_full_stt", rd, 32'h00001006);
    apb(1, 12'h000, 32'h99, 4'h1, rd, er);
    chk("tx_ovf_err", 32'(er), 32'h1);
    apb(0, 12'h018, 32'h0, 4'h0, rd, er);
    chk("tx_ovf_int", 32'(rd[4]), 32'h1);

    // TX drain, one character per cycle in order
    tx_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("tx_drain_valid", 32'(tx_valid_o), 32'h1);
      chk("tx_drain_data", 32'(tx_data_o), 32'h41 + 32'(i));
      @(posedge clk); #1;
    end
    tx_ready_i = 1'b0;
    chk("tx_drained_valid", 32'(tx_valid_o), 32'h0);
    apb(0, 12'h010, 32'h0, 4'h0, rd, er);
    chk("tx_drained_stt", rd, 32'h00000005);

    // RX fill, overrun, ordered reads, empty read
    apb(1, 12'h00C, 32'h2, 4'h1, rd, er);
    for (int i = 0; i < 17; i++) rx_pulse(8'h60 + 8'(i), 1'b0);
    apb(0, 12'h010, 32'h0, 4'h0, rd, er);
    chk("rx_full_stt", rd, 32'h00100009);
    apb(0, 12'h018, 32'h0, 4'h0, rd, er);
    chk("rx_ovr_int", 32'(rd[2]), 32'h1);
    for (int i = 0; i < 16; i++) begin
      apb(0, 12'h004, 32'h0, 4'h0, rd, er);
      chk("rx_read_err", 32'(er), 32'h0);
      chk("rx_read_data", rd, 32'h60 + 32'(i));
    end
    apb(0, 12'h004, 32'h0, 4'h0, rd, er);
    chk("rx_empty_err", 32'(er), 32'h1);
    chk("rx_empty_data", rd, 32'h0);

    // Parity interrupt latency and W1C release
    apb(1, 12'h018, 32'h1F, 4'h1, rd, er);
    apb(1, 12'h014, 32'h08, 4'h1, rd, er);
    @(posedge clk); #1;
    chk("irq_idle", 32'(irq_o), 32'h0);
    rx_pulse(8'h33, 1'b1);
    chk("irq_lat1", 32'(irq_o), 32'h0);
    @(posedge clk); #1;
    chk("irq_lat2", 32'(irq_o), 32'h1);
    apb(1, 12'h018, 32'h08, 4'h1, rd, er);
    @(posedge clk); #1;
    chk("irq_cleared", 32'(irq_o), 32'h0);
    apb(0, 12'h004, 32'h0, 4'h0, rd, er);
    chk("rx_parity_char", rd, 32'h33);

    // Asynchronous reset in the middle of TX traffic
    apb(1, 12'h00C, 32'h1, 4'h1, rd, er);
    for (int i = 0; i < 3; i++) apb(1, 12'h000, 32'hA0 + 32'(i), 4'h1, rd, er);
    chk("mid_tx_valid", 32'(tx_valid_o), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(tx_valid_o), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", 32'(tx_valid_o), 32'h0);
    apb(0, 12'h010, 32'h0, 4'h0, rd, er);
    chk("post_rst_stt", rd, 32'h00000005);

    // Bring DUT to a known state for the random phase
    apb(1, 12'h014, 32'h0, 4'h1, rd, er);
    apb(1, 12'h00C, 32'h0F, 4'h1, rd, er);
    apb(1, 12'h018, 32'h1F, 4'h1, rd, er);
    m_txq.delete(); m_rxq.delete();
    m_stt = 5'h01; m_en = 5'h00; m_irq = 1'b0; m_txen = 1'b1; m_rxen = 1'b1;

    for (int k = 0; k < 600; k++) begin
      op = $urandom_range(0, 11);
      case (op)
        0, 1: begin
          b = 8'($urandom);
          full = (m_txq.size() == 16);
          m_tick(5'h0, 5'h0);
          apb(1, 12'h000, 32'(b), 4'h1, rd, er);
          chk("rnd_tx_err", 32'(er), 32'(full));
          m_tick(full ? 5'h10 : 5'h00, 5'h0);
          if (!full) m_txq.push_back(b);
        end
        2: begin
          m_tick(5'h0, 5'h0);
          apb(0, 12'h004, 32'h0, 4'h0, rd, er);
          chk("rnd_rx_err", 32'(er), 32'(m_rxq.size() == 0));
          chk("rnd_rx_data", rd, (m_rxq.size() == 0) ? 32'h0 : 32'(m_rxq[0]));
          m_tick(5'h0, 5'h0);
          if (m_rxq.size() != 0) void'(m_rxq.pop_front());
        end
        3, 4: begin
          b = 8'($urandom);
          par = ($urandom_range(0, 3) == 0);
          rx_valid_i = 1'b1; rx_data_i = b; parity_error_i = par;
          @(posedge clk);
          ev = 5'h0;
          if (m_rxen) begin
            ev[3] = par;
            ev[2] = (m_rxq.size() == 16);
          end
          m_tick(ev, 5'h0);
          if (m_rxen && m_rxq.size() < 16) m_rxq.push_back(b);
          #1;
          rx_valid_i = 1'b0; parity_error_i = 1'b0;
        end
        5, 6: begin
          tx_ready_i = 1'b1;
          #1;
          expv = m_txen && (m_txq.size() != 0);
          chk("rnd_tx_valid", 32'(tx_valid_o), 32'(expv));
          if (expv) chk("rnd_tx_data", 32'(tx_data_o), 32'(m_txq[0]));
          @(posedge clk);
          m_tick(5'h0, 5'h0);
          if (expv) void'(m_txq.pop_front());
          #1;
          tx_ready_i = 1'b0;
        end
        7: begin
          m_tick(5'h0, 5'h0);
          apb(0, 12'h010, 32'h0, 4'h0, rd, er);
          chk("rnd_stt", rd, m_stt_word());
          m_tick(5'h0, 5'h0);
        end
        8: begin
          m_tick(5'h0, 5'h0);
          apb(0, 12'h018, 32'h0, 4'h0, rd, er);
          chk("rnd_int_stt", rd, 32'(m_stt));
          m_tick(5'h0, 5'h0);
        end
        9: begin
          d = 32'($urandom_range(0, 31));
          m_tick(5'h0, 5'h0);
          apb(1, 12'h018, d, 4'h1, rd, er);
          m_tick(5'h0, d[4:0]);
        end
        10: begin
          d = 32'($urandom_range(0, 31));
          m_tick(5'h0, 5'h0);
          apb(1, 12'h014, d, 4'h1, rd, er);
          m_tick(5'h0, 5'h0);
          m_en = d[4:0];
        end
        default: begin
          d = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'h3;
          if ($urandom_range(0, 5) == 0) d = d | 32'($urandom_range(1, 3) << 2);
          m_tick(5'h0, 5'h0);
          apb(1, 12'h00C, d, 4'h1, rd, er);
          m_tick(5'h0, 5'h0);
          m_txen = d[0];
          m_rxen = d[1];
          if (d[2]) m_txq.delete();
          if (d[3]) m_rxq.delete();
        end
      endcase
      chk("rnd_irq", 32'(irq_o), 32'(m_irq));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
